// File: rtl/regfile_scrub.sv
// regfile_scrub: parametrised 2-read/1-write register file for the multi-cycle CPU.
//   - optional hard-wired zero register, optional write-to-read bypass
//   - per-register pending scoreboard (set on issue, cleared on writeback)
//   - sequential scrub engine clearing one entry per cycle while Busy is high
// Ports:
//   CLK, CLR                 clock, asynchronous active-low reset
//   ReadRegA/B -> ReadDataA/B combinational read ports
//   WriteReg, WriteData, WE  writeback port (WE also clears the pending bit)
//   IssueReg, IssueValid     marks a destination register pending
//   PendA/B                  combinational pending status of ReadRegA/B
//   ClrReq -> Busy           scrub request / scrub in progress
module regfile_scrub #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic [ADDR_W-1:0] ReadRegA,
   input  logic [ADDR_W-1:0] ReadRegB,
   output logic [DATA_W-1:0] ReadDataA,
   output logic [DATA_W-1:0] ReadDataB,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              WE,
   input  logic [ADDR_W-1:0] IssueReg,
   input  logic              IssueValid,
   output logic              PendA,
   output logic              PendB,
   input  logic              ClrReq,
   output logic              Busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic        HAS_ZERO = (ZERO_REG != 0);
   localparam logic        HAS_BYP  = (BYPASS != 0);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SCRUB = 1'b1;

   logic [0:0]        state;
   logic [0:0]        stateNxt;
   logic [ADDR_W-1:0] scrubCnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  pend;

   logic isIdle;
   logic lastEntry;
   logic wrEn;
   logic issueEn;
   logic zeroA, zeroB;
   logic bypA, bypB;

   assign isIdle    = (state == IDLE);
   assign lastEntry = (scrubCnt == ADDR_W'(DEPTH - 1));
   // Writes and issues only land in IDLE; the zero register is never touched.
   assign wrEn      = isIdle && WE && !(HAS_ZERO && (WriteReg == '0));
   assign issueEn   = isIdle && IssueValid && !(HAS_ZERO && (IssueReg == '0));

   // State register
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) state <= IDLE;
      else      state <= stateNxt;
   end

   // Next-state logic
   always_comb begin
      stateNxt = state;
      case (state)
         IDLE:    if (ClrReq)    stateNxt = SCRUB;
         SCRUB:   if (lastEntry) stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   // Array, scoreboard and scrub counter
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         pend     <= '0;
         scrubCnt <= '0;
      end else if (state == SCRUB) begin
         mem[scrubCnt]  <= '0;
         pend[scrubCnt] <= 1'b0;
         // Natural wrap leaves the counter at 0 for the next scrub.
         scrubCnt       <= scrubCnt + ADDR_W'(1);
      end else begin
         if (wrEn) begin
            mem[WriteReg]  <= WriteData;
            pend[WriteReg] <= 1'b0;
         end
         // Issue after writeback so a same-register issue wins.
         if (issueEn) pend[IssueReg] <= 1'b1;
         scrubCnt <= '0;
      end
   end

   // Read ports: zero register, then bypass, then array
   assign zeroA = HAS_ZERO && (ReadRegA == '0);
   assign zeroB = HAS_ZERO && (ReadRegB == '0);
   assign bypA  = HAS_BYP && isIdle && WE && (WriteReg == ReadRegA);
   assign bypB  = HAS_BYP && isIdle && WE && (WriteReg == ReadRegB);

   always_comb begin
      ReadDataA = mem[ReadRegA];
      ReadDataB = mem[ReadRegB];
      PendA     = pend[ReadRegA];
      PendB     = pend[ReadRegB];
      if (zeroA) begin
         ReadDataA = '0;
         PendA     = 1'b0;
      end else if (bypA) begin
         ReadDataA = WriteData;
         PendA     = 1'b0;
      end
      if (zeroB) begin
         ReadDataB = '0;
         PendB     = 1'b0;
      end else if (bypB) begin
         ReadDataB = WriteData;
         PendB     = 1'b0;
      end
   end

   // Busy is a direct decode of the state flop
   assign Busy = (state == SCRUB);

endmodule

// File: tb/tb_regfile_scrub.sv
module tb_regfile_scrub;

   logic        CLK;
   logic        CLR;
   logic [4:0]  ReadRegA, ReadRegB, WriteReg, IssueReg;
   logic [31:0] ReadDataA, ReadDataB, WriteData;
   logic        WE, IssueValid, PendA, PendB, ClrReq, Busy;

   logic [2:0]  ReadRegA2, ReadRegB2, WriteReg2, IssueReg2;
   logic [15:0] ReadDataA2, ReadDataB2, WriteData2;
   logic        WE2, IssueValid2, PendA2, PendB2, ClrReq2, Busy2;

   int total = 0;
   int bad   = 0;

   // Reference model: plain arrays following the behavioural rules
   logic [31:0] refMem [32];
   bit          refPend [32];
   bit          refBusy;
   int          refIdx;

   regfile_scrub u_dut (
      .CLK(CLK), .CLR(CLR),
      .ReadRegA(ReadRegA), .ReadRegB(ReadRegB),
      .ReadDataA(ReadDataA), .ReadDataB(ReadDataB),
      .WriteReg(WriteReg), .WriteData(WriteData), .WE(WE),
      .IssueReg(IssueReg), .IssueValid(IssueValid),
      .PendA(PendA), .PendB(PendB),
      .ClrReq(ClrReq), .Busy(Busy)
   );

   regfile_scrub #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_small (
      .CLK(CLK), .CLR(CLR),
      .ReadRegA(ReadRegA2), .ReadRegB(ReadRegB2),
      .ReadDataA(ReadDataA2), .ReadDataB(ReadDataB2),
      .WriteReg(WriteReg2), .WriteData(WriteData2), .WE(WE2),
      .IssueReg(IssueReg2), .IssueValid(IssueValid2),
      .PendA(PendA2), .PendB(PendB2),
      .ClrReq(ClrReq2), .Busy(Busy2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] expRd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (!refBusy && WE && WriteReg == a) return WriteData;
      return refMem[a];
   endfunction

   function automatic logic expPend(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      if (!refBusy && WE && WriteReg == a) return 1'b0;
      return refPend[a];
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 32; i++) begin
         refMem[i]  = 32'd0;
         refPend[i] = 1'b0;
      end
      refBusy = 1'b0;
      refIdx  = 0;
   endtask

   task automatic modelEdge();
      if (!refBusy) begin
         if (WE && WriteReg != 5'd0) refMem[WriteReg] = WriteData;
         if (WE) refPend[WriteReg] = 1'b0;
         if (IssueValid && IssueReg != 5'd0) refPend[IssueReg] = 1'b1;
         if (ClrReq) begin
            refBusy = 1'b1;
            refIdx  = 0;
         end
      end else begin
         refMem[refIdx]  = 32'd0;
         refPend[refIdx] = 1'b0;
         refIdx++;
         if (refIdx == 32) begin
            refBusy = 1'b0;
            refIdx  = 0;
         end
      end
   endtask

   task automatic cmpModel();
      check("rdA",  64'(ReadDataA), 64'(expRd(ReadRegA)));
      check("rdB",  64'(ReadDataB), 64'(expRd(ReadRegB)));
      check("pndA", 64'(PendA),     64'(expPend(ReadRegA)));
      check("pndB", 64'(PendB),     64'(expPend(ReadRegB)));
      check("busy", 64'(Busy),      64'(refBusy));
   endtask

   task automatic setIn(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic iv, input logic [4:0] ir, input logic cr);
      WE = we; WriteReg = wr; WriteData = wd;
      ReadRegA = ra; ReadRegB = rb;
      IssueValid = iv; IssueReg = ir; ClrReq = cr;
   endtask

   // Compare against the model, then advance one clock with the model in lockstep.
   task automatic step();
      #1;
      cmpModel();
      @(posedge CLK);
      modelEdge();
      @(negedge CLK);
   endtask

   initial begin
      int busyCnt;
      CLR = 1'b0;
      setIn(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0);
      WE2 = 0; WriteReg2 = 0; WriteData2 = 0; ReadRegA2 = 0; ReadRegB2 = 0;
      IssueValid2 = 0; IssueReg2 = 0; ClrReq2 = 0;
      modelReset();
      repeat (2) @(negedge CLK);
      // Reset state
      check("rst_rdA", 64'(ReadDataA), 64'd0);
      check("rst_pndA", 64'(PendA), 64'd0);
      check("rst_busy", 64'(Busy), 64'd0);
      CLR = 1'b1;
      @(negedge CLK);

      // Bypass of a same-cycle write, then stored value
      setIn(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0);
      #1 check("byp_rdA", 64'(ReadDataA), 64'hDEADBEEF);
      step();
      setIn(1'b0, 5'd5, 32'd0, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
      #1 check("stored_rdA", 64'(ReadDataA), 64'hDEADBEEF);
      step();

      // Zero register: writes dropped, issue ignored
      setIn(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      #1 check("r0_byp", 64'(ReadDataA), 64'd0);
      step();
      setIn(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
      #1 check("r0_rdB", 64'(ReadDataB), 64'd0);
      step();
      setIn(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      #1 check("r0_pnd", 64'(PendA), 64'd0);
      step();

      // Scoreboard: issue, write clears (same cycle), issue+write keeps pending
      setIn(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0);
      #1 check("iss_same_cyc", 64'(PendA), 64'd0);
      step();
      setIn(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
      #1 check("iss_next_cyc", 64'(PendA), 64'd1);
      step();
      setIn(1'b1, 5'd7, 32'h55, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
      #1 check("wr_clr_pnd", 64'(PendA), 64'd0);
      step();
      setIn(1'b1, 5'd7, 32'h66, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0);
      step();
      setIn(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
      #1 check("set_wins", 64'(PendA), 64'd1);
      step();

      // Fill r1..r31, leave some pending, scrub with lost writes during Busy
      for (int i = 1; i < 32; i++) begin
         setIn(1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1), (i % 4) == 0, 5'(i - 1), 1'b0);
         step();
      end
      setIn(1'b0, 5'd0, 32'd0, 5'd3, 5'd8, 1'b0, 5'd0, 1'b1);
      step();
      busyCnt = 0;
      for (int i = 0; i < 40; i++) begin
         setIn(refBusy, 5'd3, 32'h99, 5'd3, 5'd31, refBusy, 5'd3, 1'b0);
         #1 if (Busy) busyCnt++;
         step();
      end
      check("scrub_len", 64'(busyCnt), 64'd32);
      for (int a = 0; a < 32; a++) begin
         setIn(1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a), 1'b0, 5'd0, 1'b0);
         #1 check("post_scrub_rd", 64'(ReadDataA), 64'd0);
         check("post_scrub_pnd", 64'(PendB), 64'd0);
         step();
      end

      // Randomised traffic including occasional scrubs
      for (int n = 0; n < 800; n++) begin
         logic [4:0] wr;
         wr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         setIn(1'($urandom_range(0, 1)), wr, $urandom,
               ($urandom_range(0, 2) == 0) ? wr : 5'($urandom), 5'($urandom),
               1'($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0) ? wr : 5'($urandom),
               $urandom_range(0, 59) == 0);
         step();
      end
      // Drain any scrub still running
      for (int i = 0; i < 40 && refBusy; i++) begin
         setIn(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
         step();
      end

      // Async reset mid-scrub at counter=10
      for (int i = 1; i < 32; i++) begin
         setIn(1'b1, 5'(i), 32'(i), 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
         step();
      end
      setIn(1'b0, 5'd0, 32'd0, 5'd20, 5'd9, 1'b0, 5'd0, 1'b1);
      step();
      setIn(1'b0, 5'd0, 32'd0, 5'd20, 5'd9, 1'b0, 5'd0, 1'b0);
      repeat (10) step();
      #1 check("pre_rst_r20", 64'(ReadDataA), 64'd20);
      check("pre_rst_r9", 64'(ReadDataB), 64'd0);
      #1 CLR = 1'b0;
      #1 check("rst_busy_now", 64'(Busy), 64'd0);
      check("rst_r20_now", 64'(ReadDataA), 64'd0);
      modelReset();
      @(negedge CLK);
      CLR = 1'b1;
      setIn(1'b1, 5'd9, 32'h77, 5'd20, 5'd9, 1'b0, 5'd0, 1'b0);
      step();
      setIn(1'b0, 5'd0, 32'd0, 5'd9, 5'd20, 1'b0, 5'd0, 1'b0);
      #1 check("post_rst_wr", 64'(ReadDataA), 64'h77);
      check("post_rst_idle", 64'(Busy), 64'd0);
      step();

      // Small configuration: no zero register, 8 entries
      WE2 = 1; WriteReg2 = 0; WriteData2 = 16'hABCD; ReadRegA2 = 0; ReadRegB2 = 1;
      #1 check("s_byp_r0", 64'(ReadDataA2), 64'hABCD);
      @(negedge CLK);
      WE2 = 0;
      #1 check("s_rd_r0", 64'(ReadDataA2), 64'hABCD);
      IssueValid2 = 1; IssueReg2 = 0;
      @(negedge CLK);
      IssueValid2 = 0;
      #1 check("s_pnd_r0", 64'(PendA2), 64'd1);
      ClrReq2 = 1;
      @(negedge CLK);
      ClrReq2 = 0;
      busyCnt = 0;
      for (int i = 0; i < 12; i++) begin
         #1 if (Busy2) busyCnt++;
         @(negedge CLK);
      end
      check("s_scrub_len", 64'(busyCnt), 64'd8);
      #1 check("s_post_rd", 64'(ReadDataA2), 64'd0);
      check("s_post_pnd", 64'(PendA2), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_scrub.md
Name: regfile_scrub

Overview:
- Parametrised successor to the CPU's 2-read/1-write general-purpose register file.
- Adds configurable data width and depth, an optional hard-wired zero register, and write-to-read bypass.
- Adds a per-register pending scoreboard for multi-cycle writeback hazard detection.
- Adds a sequential scrub engine that clears the array one entry per cycle under a busy flag.
- Sits between the decode stage (reads, issue) and the writeback stage (writes) of the multi-cycle CPU.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, when 1 entry 0 always reads 0, is never written and is never marked pending.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  reset, asynchronous, active-low.
- ReadRegA  in  ADDR_W  read address A.
- ReadRegB  in  ADDR_W  read address B.
- ReadDataA  out  DATA_W  read data A, combinational.
- ReadDataB  out  DATA_W  read data B, combinational.
- WriteReg  in  ADDR_W  write address.
- WriteData  in  DATA_W  write data.
- WE  in  1  write enable; also clears the pending bit of WriteReg.
- IssueReg  in  ADDR_W  destination of a newly issued instruction.
- IssueValid  in  1  sets the pending bit of IssueReg.
- PendA  out  1  pending status of ReadRegA, combinational.
- PendB  out  1  pending status of ReadRegB, combinational.
- ClrReq  in  1  single-cycle request to start a scrub.
- Busy  out  1  high while a scrub is in progress.

Behaviour:
- Reset (CLR=0, asynchronous):
  - all entries 0, all pending bits 0, FSM in IDLE, scrub counter 0, Busy=0.
  - Reads therefore return 0 and PendA/PendB=0 during reset.
- Write:
  - At the rising edge, mem[WriteReg] <= WriteData when WE=1 and state=IDLE.
  - Suppressed when WriteReg=0 and ZERO_REG=1.
- Read (per port X in A/B), first matching rule wins:
  - ZERO_REG=1 and ReadRegX=0 -> 0.
  - BYPASS=1, state=IDLE, WE=1, WriteReg=ReadRegX -> WriteData.
  - Otherwise -> mem[ReadRegX].
- Pending scoreboard, updated at the rising edge in IDLE only:
  - IssueValid=1 sets pend[IssueReg].
  - WE=1 clears pend[WriteReg].
  - Same register issued and written in the same cycle: set wins (the newer issue owns the register).
  - Register 0 is never set when ZERO_REG=1.
- PendX (combinational):
  - PendX = pend[ReadRegX], forced to 0 when BYPASS=1 and a write to ReadRegX is bypassed this cycle.
  - PendX is 0 for ReadRegX=0 when ZERO_REG=1.
  - Issuing in the current cycle does not affect PendX until the next cycle.
- Scrub FSM states: IDLE, SCRUB.
  - IDLE -> SCRUB on ClrReq=1; counter <= 0.
  - In SCRUB, each cycle: mem[counter] <= 0 and pend[counter] <= 0; counter increments.
  - SCRUB -> IDLE on the cycle that clears entry DEPTH-1; counter wraps to 0.
  - Busy=1 exactly while in SCRUB, i.e. DEPTH cycles. Busy rises the cycle after ClrReq is sampled.
  - In SCRUB: WE and IssueValid are ignored (writes and issues are lost), bypass is disabled, ClrReq is ignored.
  - Reads in SCRUB return current array contents: scrubbed entries read 0, later entries keep old data.
  - A ClrReq coinciding with WE/IssueValid in IDLE: the write and issue take effect that edge, then the scrub clears them.
- Reset mid-scrub: immediate return to IDLE with everything zeroed; the scrub does not resume.

Test Plan:
- Write 0xDEADBEEF to r5 with ReadRegA=5 in the same cycle -> ReadDataA=0xDEADBEEF combinationally (BYPASS=1); next cycle, with WE=0, still 0xDEADBEEF.
- WE=1, WriteReg=0, WriteData=0x1234; then read r0 on both ports -> ReadDataA=ReadDataB=0; IssueValid to r0 -> PendA=0.
- Issue r7; next cycle PendA(ReadRegA=7)=1; write r7 with 0x55 -> PendA=0 in the same cycle; simultaneous issue+write r7 -> PendA=1 the following cycle.
- Fill r1..r31 with their index; pulse ClrReq -> Busy high for 32 cycles; a WE to r3 during Busy has no effect; after Busy falls all reads return 0 and all PendX=0.
- Assert CLR=0 asynchronously mid-scrub (counter=10, r20 still holding 20) -> Busy=0 and r20 reads 0 immediately; after release the FSM is in IDLE and a normal write succeeds.
- DATA_W=16, ADDR_W=3, ZERO_REG=0: write 0xABCD to r0 -> reads back 0xABCD; scrub -> Busy for 8 cycles.
